// File: rtl/risc_cpu.sv
// risc_cpu: 8-bit accumulator processor with a 13-bit address space.
// Each 16-bit instruction is fetched as two bytes (opcode/high address at the
// even address, low address at the odd one) and executes in a fixed
// eight-state cycle S0..S7.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset    synchronous active-high reset
//   halt     high while an HLT instruction is in S3 (or parked, see below)
//   rd / wr  memory read / write strobes, never high together
//   addr     memory address: pc during fetch (S0-S3), ir_addr during S4-S7
//   data     shared bus; the CPU drives it only for STO in S4-S6
//   opcode   ir[15:13] (debug)
//   fetch    high during the fetch half S0-S3
//   ir_addr  ir[12:0], operand address (debug)
//   pc_addr  program counter (debug)
//
// Build option: define RISC_CPU_HALT_LATCH_EN to make HLT park the machine in
// a HALTED state (halt held high, no strobes, pc/acc frozen) until reset.
// Without it, halt is a single-state pulse and execution carries on.
module risc_cpu #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          halt,
    output logic          rd,
    output logic          wr,
    output logic [AW-1:0] addr,
    inout  logic [DW-1:0] data,
    output logic [2:0]    opcode,
    output logic          fetch,
    output logic [AW-1:0] ir_addr,
    output logic [AW-1:0] pc_addr
);

    typedef enum logic [3:0] {
        S0, S1, S2, S3, S4, S5, S6, S7, HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } op_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [2*DW-1:0] ir;
    logic [DW-1:0]   acc;
    op_t             op;
    logic            zero;
    logic            is_alu;
    logic            is_sto;
    logic            drive;

    assign op      = op_t'(ir[2*DW-1 -: 3]);
    assign opcode  = ir[2*DW-1 -: 3];
    assign ir_addr = ir[AW-1:0];
    assign pc_addr = pc;
    assign zero    = (acc == '0);
    assign is_alu  = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    assign is_sto  = (op == OP_STO);

    // Bus is released whenever drive is low; drive never overlaps rd.
    assign data = drive ? acc : 'z;

    // Strobes are decoded from the registered state and gated by reset so
    // that an instruction interrupted by reset cannot complete a write at
    // the reset edge, and the bus is idle while reset is held.
    always_comb begin
        fetch = (state == S0) || (state == S1) || (state == S2) || (state == S3);
        addr  = fetch ? pc : ir_addr;
        rd    = 1'b0;
        wr    = 1'b0;
        drive = 1'b0;
        halt  = 1'b0;
        if (!reset) begin
            case (state)
                S0, S1:  rd = 1'b1;
                S3:      halt = (op == OP_HLT);
                S4: begin
                    rd    = is_alu;
                    drive = is_sto;
                end
                S5: begin
                    rd    = is_alu;
                    drive = is_sto;
                    wr    = is_sto;
                end
                S6:      drive = is_sto;
                HALTED:  halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S0: begin
                    ir[2*DW-1:DW] <= data;
                    pc            <= pc + AW'(1);
                    state         <= S1;
                end
                S1: begin
                    ir[DW-1:0] <= data;
                    pc         <= pc + AW'(1);
                    state      <= S2;
                end
                S2: state <= S3;
                S3: begin
`ifdef RISC_CPU_HALT_LATCH_EN
                    if (op == OP_HLT) begin
                        state <= HALTED;
                    end else begin
                        state <= S4;
                    end
`else
                    state <= S4;
`endif
                end
                S4: begin
                    if (op == OP_JMP) begin
                        pc <= ir_addr;
                    end else if ((op == OP_SKZ) && zero) begin
                        pc <= pc + AW'(2);
                    end
                    state <= S5;
                end
                S5: begin
                    case (op)
                        OP_ADD:  acc <= acc + data;
                        OP_AND:  acc <= acc & data;
                        OP_XOR:  acc <= acc ^ data;
                        OP_LDA:  acc <= data;
                        default: ;
                    endcase
                    state <= S6;
                end
                S6: state <= S7;
                S7: state <= S0;
                HALTED: state <= HALTED;
                default: state <= S0;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_cpu.sv
// tb_risc_cpu: testbench for risc_cpu. Provides ROM/RAM behind the shared bus,
// an instruction-level reference model that predicts the stream of fetches,
// stores and halts, and a monitor that compares what the CPU does against it.
module tb_risc_cpu;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDI = 3'd3,
                           XORI = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    localparam int EV_FETCH = 0, EV_WRITE = 1, EV_HALT = 2;

    typedef struct {
        int          kind;
        logic [12:0] a;
        logic [7:0]  d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt, rd, wr, fetch;
    logic [12:0] addr, ir_addr, pc_addr;
    logic [2:0]  opcode;
    wire  [7:0]  data;

    logic [7:0]  rom [8192];
    logic [7:0]  ram [1024];
    logic [7:0]  m_ram [1024];
    logic [7:0]  mem_q;

    ev_t         exp_q[$];
    logic [7:0]  fib_log[$];
    int          checks = 0;
    int          errors = 0;
    bit          armed = 0;
    bit          fib_mode = 0;
    int          overlap_cnt = 0;
    int          wr_long_cnt = 0;
    bit          prev_fetch = 0, prev_wr = 0, prev_halt = 0;

    risc_cpu #(.AW(13), .DW(8)) dut (
        .clk(clk), .reset(reset), .halt(halt), .rd(rd), .wr(wr),
        .addr(addr), .data(data), .opcode(opcode), .fetch(fetch),
        .ir_addr(ir_addr), .pc_addr(pc_addr)
    );

    always #5 clk = ~clk;

    // System memory: RAM at 0x1800-0x1FFF (10-bit index), ROM elsewhere.
    always_comb mem_q = (addr[12:11] == 2'b11) ? ram[addr[9:0]] : rom[addr];
    assign data = rd ? mem_q : 8'hzz;

    always @(posedge clk) begin
        if (wr && addr[12:11] == 2'b11) ram[addr[9:0]] = data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic got(input int kind, input logic [12:0] a, input logic [7:0] d);
        ev_t e;
        if (!armed) return;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h expected none", kind, a, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.a !== a || e.d !== d) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
                     kind, a, d, e.kind, e.a, e.d);
        end
    endtask

    // Monitor: one event per fetch start, per write pulse and per halt rise.
    always @(negedge clk) begin
        if (reset) begin
            prev_fetch = 0;
            prev_wr    = 0;
            prev_halt  = 0;
        end else begin
            if (rd && wr) overlap_cnt++;
            if (wr && prev_wr) wr_long_cnt++;
            if (fetch && !prev_fetch) got(EV_FETCH, addr, 8'h00);
            if (wr && !prev_wr) got(EV_WRITE, addr, data);
            if (halt && !prev_halt) got(EV_HALT, addr, 8'h00);
            if (fib_mode && !fetch && prev_fetch && opcode == SKZ) fib_log.push_back(ram[2]);
            prev_fetch = fetch;
            prev_wr    = wr;
            prev_halt  = halt;
        end
    end

    function automatic logic [7:0] mread(input logic [12:0] a);
        return (a[12:11] == 2'b11) ? m_ram[a[9:0]] : rom[a];
    endfunction

    // Instruction-level reference: executes n instructions from pc=0, acc=0
    // on a copy of RAM and records the externally visible events in order.
    task automatic build_expected(input int n);
        logic [12:0] pc, a;
        logic [7:0]  acc, b0, b1;
        ev_t         e;
        pc  = '0;
        acc = '0;
        m_ram = ram;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            e = '{EV_FETCH, pc, 8'h00};
            exp_q.push_back(e);
            b0 = mread(pc);
            b1 = mread(pc + 13'd1);
            a  = {b0[4:0], b1};
            pc = pc + 13'd2;
            case (b0[7:5])
                HLT: begin
                    e = '{EV_HALT, pc, 8'h00};
                    exp_q.push_back(e);
`ifdef RISC_CPU_HALT_LATCH_EN
                    break;
`endif
                end
                SKZ:  if (acc == 0) pc = pc + 13'd2;
                ADD:  acc = acc + mread(a);
                ANDI: acc = acc & mread(a);
                XORI: acc = acc ^ mread(a);
                LDA:  acc = mread(a);
                STO: begin
                    e = '{EV_WRITE, a, acc};
                    exp_q.push_back(e);
                    if (a[12:11] == 2'b11) m_ram[a[9:0]] = acc;
                end
                default: pc = a;
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    endtask

    task automatic put(input logic [12:0] at, input logic [2:0] op, input logic [12:0] a);
        rom[at]         = {op, a[12:8]};
        rom[at + 13'd1] = a[7:0];
    endtask

    task automatic run_prog(input string name, input int n);
        build_expected(n);
        reset = 1'b1;
        armed = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        armed = 1;
        repeat (8 * n) @(posedge clk);
        #1 reset = 1'b1;
        armed = 0;
        chk({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int         n_fib;
        logic [7:0] x, y, z;
        logic [12:0] a;
        logic [2:0] op;
        bit         seen;

        // Reset behaviour and first fetch.
        clear_mem();
        put(13'h0000, LDA, 13'h1800);
        put(13'h0002, STO, 13'h1801);
        ram[0] = 8'h5A;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", rd, 0);
        chk("reset_wr", wr, 0);
        chk("reset_halt", halt, 0);
        chk("reset_pc", pc_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_addr", addr, 13'h0000);
        chk("first_rd", rd, 1);
        chk("first_fetch", fetch, 1);
        @(posedge clk); #1;
        chk("pc_after_s0", pc_addr, 13'h0001);
        @(posedge clk); #1;
        chk("pc_after_s1", pc_addr, 13'h0002);
        reset = 1'b1;

        // Load/store.
        run_prog("ldsto", 3);
        chk("ldsto_ram1", ram[1], 8'h5A);

        // Reset landing in S5 of STO must suppress the write.
        ram[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wr) seen = 1;
        end
        chk("midsto_wr_seen", seen, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midsto_wr_low", wr, 0);
        chk("midsto_rd_low", rd, 0);
        chk("midsto_no_write", ram[1], 8'h00);
        chk("midsto_pc", pc_addr, 0);

        // ALU, SKZ both ways, JMP, HLT and pc wrap via RAM at 0x1FFE.
        clear_mem();
        put(13'h0000, LDA, 13'h1804);
        put(13'h0002, SKZ, 13'h0000);
        put(13'h0004, JMP, 13'h0010);
        put(13'h0006, HLT, 13'h0000);
        put(13'h0008, LDA, 13'h1808);
        put(13'h000A, STO, 13'h1809);
        put(13'h000C, JMP, 13'h1FFE);
        put(13'h0010, LDA, 13'h1800);
        put(13'h0012, ADD, 13'h1801);
        put(13'h0014, SKZ, 13'h0000);
        put(13'h0016, STO, 13'h1802);
        put(13'h0018, STO, 13'h1803);
        put(13'h001A, LDA, 13'h1804);
        put(13'h001C, ANDI, 13'h1805);
        put(13'h001E, STO, 13'h1806);
        put(13'h0020, XORI, 13'h1806);
        put(13'h0022, STO, 13'h1807);
        put(13'h0024, JMP, 13'h0006);
        ram[0] = 8'hFF; ram[1] = 8'h01; ram[2] = 8'hEE; ram[3] = 8'h77;
        ram[4] = 8'h0F; ram[5] = 8'h3C; ram[6] = 8'h99; ram[7] = 8'h55;
        ram[8] = 8'h5A; ram[9] = 8'h00;
        ram[10'h3FE] = {LDA, 5'h18};
        ram[10'h3FF] = 8'h08;
        run_prog("alu", 20);
        chk("skz_skipped_sto", ram[2], 8'hEE);
        chk("add_wrap_zero", ram[3], 8'h00);
        chk("and_result", ram[6], 8'h0C);
        chk("xor_result", ram[7], 8'h00);
`ifndef RISC_CPU_HALT_LATCH_EN
        chk("after_hlt_sto", ram[9], 8'h5A);
`else
        chk("halted_no_sto", ram[9], 8'h00);
`endif

        // Fibonacci loop over RAM 0x1800-0x1802.
        clear_mem();
        put(13'h0000, LDA, 13'h1800);
        put(13'h0002, ADD, 13'h1801);
        put(13'h0004, STO, 13'h1802);
        put(13'h0006, LDA, 13'h1801);
        put(13'h0008, STO, 13'h1800);
        put(13'h000A, LDA, 13'h1802);
        put(13'h000C, STO, 13'h1801);
        put(13'h000E, XORI, 13'h1803);
        put(13'h0010, SKZ, 13'h0000);
        put(13'h0012, JMP, 13'h0000);
        put(13'h0014, HLT, 13'h0000);
        put(13'h0016, JMP, 13'h0014);
        ram[0] = 8'd0; ram[1] = 8'd1; ram[3] = 8'd144;
        fib_log.delete();
        fib_mode = 1;
        run_prog("fib", 114);
        fib_mode = 0;
        x = 8'd0; y = 8'd1; n_fib = 0;
        do begin
            z = x + y;
            if (n_fib < fib_log.size()) chk("fib_value", fib_log[n_fib], z);
            n_fib++;
            x = y;
            y = z;
        end while (z != 8'd144);
        chk("fib_count", fib_log.size(), n_fib);
        chk("fib_final", ram[2], 8'd144);

        // Random programs in 0x0000-0x003F, data in RAM 0x1800+ and ROM 0x0100+.
        for (int p = 0; p < 6; p++) begin
            clear_mem();
            for (int i = 0; i < 16; i++) begin
                ram[i]        = 8'($urandom);
                rom[256 + i]  = 8'($urandom);
            end
            for (int s = 0; s < 32; s++) begin
                op = 3'($urandom_range(0, 7));
                case (op)
                    JMP:      a = 13'($urandom_range(0, 31) * 2);
                    STO:      a = 13'h1800 + 13'($urandom_range(0, 15));
                    HLT, SKZ: a = 13'($urandom);
                    default:  a = ($urandom_range(0, 1) != 0) ? 13'h1800 + 13'($urandom_range(0, 15))
                                                              : 13'h0100 + 13'($urandom_range(0, 15));
                endcase
                put(13'(s * 2), op, a);
            end
            run_prog("rand", 40);
        end

        chk("rd_wr_overlap", overlap_cnt, 0);
        chk("wr_single_clk", wr_long_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
